// File: rtl/simmem_delay_releaser.sv
// Per-ID delay tracker: each accepted request holds a slot that counts down its delay,
// expired slots raise release_en for their ID, and bank handshakes retire them.
module simmem_delay_releaser #(
   parameter int unsigned IDWidth    = 4,
   parameter int unsigned NumSlots   = 8,
   parameter int unsigned DelayWidth = 8
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          req_valid_i,
   output logic                          req_ready_o,
   input  logic [IDWidth-1:0]            req_id_i,
   input  logic [DelayWidth-1:0]         req_delay_i,
   output logic [(2**IDWidth)-1:0]       release_en_o,
   input  logic                          done_valid_i,
   input  logic [IDWidth-1:0]            done_id_i,
   output logic [$clog2(NumSlots):0]     occupancy_o,
   output logic                          err_o
);

   localparam int unsigned OccWidth = $clog2(NumSlots) + 1;

   logic [NumSlots-1:0]   valid_q, valid_d;
   logic [IDWidth-1:0]    id_q  [NumSlots];
   logic [IDWidth-1:0]    id_d  [NumSlots];
   logic [DelayWidth-1:0] cnt_q [NumSlots];
   logic [DelayWidth-1:0] cnt_d [NumSlots];
   logic                  err_q, err_d;

   logic [NumSlots-1:0]   expired_s;
   logic [NumSlots-1:0]   accept_sel_s;
   logic [NumSlots-1:0]   retire_sel_s;
   logic [OccWidth-1:0]   occ_s;
   logic                  free_found_s;
   logic                  match_found_s;

   // Slot observation: expiry, per-ID release vector, occupancy and ready, all from registered state.
   always_comb begin
      release_en_o = '0;
      occ_s        = '0;
      for (int i = 0; i < NumSlots; i++) begin
         expired_s[i] = valid_q[i] && (cnt_q[i] == '0);
         if (expired_s[i]) begin
            release_en_o[id_q[i]] = 1'b1;
         end else begin
            release_en_o = release_en_o;
         end
         occ_s = occ_s + OccWidth'(valid_q[i]);
      end
      req_ready_o = !rst_i && (occ_s < OccWidth'(NumSlots));
   end

   // Priority pick of the lowest free slot for accepts and the lowest matching expired slot for retires.
   always_comb begin
      free_found_s  = 1'b0;
      match_found_s = 1'b0;
      accept_sel_s  = '0;
      retire_sel_s  = '0;
      for (int i = 0; i < NumSlots; i++) begin
         if (!valid_q[i] && !free_found_s) begin
            free_found_s    = 1'b1;
            accept_sel_s[i] = 1'b1;
         end else begin
            accept_sel_s[i] = 1'b0;
         end
         if (expired_s[i] && (id_q[i] == done_id_i) && !match_found_s) begin
            match_found_s   = 1'b1;
            retire_sel_s[i] = 1'b1;
         end else begin
            retire_sel_s[i] = 1'b0;
         end
      end
   end

   // Next-state for slots and the sticky error; accept and retire never target the same slot.
   always_comb begin
      valid_d = valid_q;
      id_d    = id_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      for (int i = 0; i < NumSlots; i++) begin
         if (valid_q[i] && (cnt_q[i] != '0)) begin
            cnt_d[i] = cnt_q[i] - DelayWidth'(1);
         end else begin
            cnt_d[i] = cnt_q[i];
         end
         if (done_valid_i && retire_sel_s[i]) begin
            valid_d[i] = 1'b0;
         end else if (req_valid_i && req_ready_o && accept_sel_s[i]) begin
            valid_d[i] = 1'b1;
            id_d[i]    = req_id_i;
            cnt_d[i]   = req_delay_i;
         end else begin
            valid_d[i] = valid_q[i];
         end
      end
      if (done_valid_i && !match_found_s) begin
         err_d = 1'b1;
      end else begin
         err_d = err_q;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= '0;
         err_q   <= 1'b0;
         for (int i = 0; i < NumSlots; i++) begin
            id_q[i]  <= '0;
            cnt_q[i] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         err_q   <= err_d;
         id_q    <= id_d;
         cnt_q   <= cnt_d;
      end
   end

   assign occupancy_o = occ_s;
   assign err_o       = err_q;

endmodule

// File: tb/tb_simmem_delay_releaser.sv
// Bench for simmem_delay_releaser: outstanding requests are modelled as (id, release cycle)
// tokens and every cycle's outputs are compared against that list, plus directed literal checks.
module tb_simmem_delay_releaser;

   localparam int NSLOTS = 8;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_id;
   logic [7:0]  req_delay;
   logic [15:0] release_en;
   logic        done_valid;
   logic [3:0]  done_id;
   logic [3:0]  occupancy;
   logic        err;

   int n_checks = 0;
   int n_errors = 0;

   int cyc = 0;
   bit model_live = 1'b0;
   int m_id[$];
   int m_rel[$];
   bit m_err = 1'b0;
   int found;
   bit acc;
   logic [15:0] exp_rel;

   simmem_delay_releaser #(.IDWidth(4), .NumSlots(NSLOTS), .DelayWidth(8)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .req_valid_i  (req_valid),
      .req_ready_o  (req_ready),
      .req_id_i     (req_id),
      .req_delay_i  (req_delay),
      .release_en_o (release_en),
      .done_valid_i (done_valid),
      .done_id_i    (done_id),
      .occupancy_o  (occupancy),
      .err_o        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Reference model: tokens carry the absolute cycle from which they count as expired.
   always @(posedge clk) begin
      if (rst) begin
         m_id.delete();
         m_rel.delete();
         m_err      = 1'b0;
         model_live = 1'b1;
      end else if (model_live) begin
         acc = req_valid && (m_id.size() < NSLOTS);
         if (done_valid) begin
            found = -1;
            foreach (m_id[i])
               if (found < 0 && m_id[i] == int'(done_id) && m_rel[i] <= cyc) found = i;
            if (found >= 0) begin
               m_id.delete(found);
               m_rel.delete(found);
            end else begin
               m_err = 1'b1;
            end
         end
         if (acc) begin
            m_id.push_back(int'(req_id));
            m_rel.push_back(cyc + 1 + int'(req_delay));
         end
      end
      cyc++;
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (model_live) begin
         exp_rel = '0;
         foreach (m_id[i])
            if (m_rel[i] <= cyc) exp_rel[m_id[i]] = 1'b1;
         chk("model_release_en", 32'(release_en), 32'(exp_rel));
         chk("model_occupancy", 32'(occupancy), 32'(m_id.size()));
         chk("model_err", 32'(err), 32'(m_err));
         chk("model_ready", 32'(req_ready), 32'(!rst && (m_id.size() < NSLOTS)));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      done_valid = 1'b0;
   endtask

   task automatic tick_hold();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   int cands[$];

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_id = '0; req_delay = '0;
      done_valid = 1'b0; done_id = '0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("reset_ready", 32'(req_ready), 32'd0);
      chk("reset_occ", 32'(occupancy), 32'd0);
      chk("reset_rel", 32'(release_en), 32'd0);
      chk("reset_err", 32'(err), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", 32'(req_ready), 32'd1);

      // Delay 5 on ID 3: low for five cycles, high in the sixth.
      req_valid = 1'b1; req_id = 4'd3; req_delay = 8'd5;
      tick();
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         chk("t1_rel3_low", 32'(release_en[3]), 32'd0);
         tick();
      end
      @(negedge clk);
      chk("t1_rel3_high", 32'(release_en[3]), 32'd1);
      chk("t1_occ", 32'(occupancy), 32'd1);
      done_valid = 1'b1; done_id = 4'd3;
      tick();
      @(negedge clk);
      chk("t1_occ_after_retire", 32'(occupancy), 32'd0);

      // Delay 0 on ID 2, retired in cycle 3.
      req_valid = 1'b1; req_id = 4'd2; req_delay = 8'd0;
      tick();
      @(negedge clk);
      chk("t2_rel2_high", 32'(release_en[2]), 32'd1);
      tick();
      tick();
      done_valid = 1'b1; done_id = 4'd2;
      tick();
      @(negedge clk);
      chk("t2_rel2_low", 32'(release_en[2]), 32'd0);
      chk("t2_occ", 32'(occupancy), 32'd0);

      // Fill all slots, hold a request, free slot 0 by retiring ID 0.
      for (int k = 0; k < 8; k++) begin
         req_valid = 1'b1; req_id = 4'(k); req_delay = 8'd10;
         tick();
      end
      req_valid = 1'b1; req_id = 4'd9; req_delay = 8'd0;
      for (int k = 8; k <= 10; k++) begin
         @(negedge clk);
         chk("t3_full_ready", 32'(req_ready), 32'd0);
         tick_hold();
      end
      @(negedge clk);
      chk("t3_rel0", 32'(release_en[0]), 32'd1);
      chk("t3_ready_at_retire", 32'(req_ready), 32'd0);
      done_valid = 1'b1; done_id = 4'd0;
      tick_hold();
      done_valid = 1'b0;
      @(negedge clk);
      chk("t3_ready_after_retire", 32'(req_ready), 32'd1);
      tick();
      @(negedge clk);
      chk("t3_occ_full", 32'(occupancy), 32'd8);
      chk("t3_ready_full", 32'(req_ready), 32'd0);
      chk("t3_rel9", 32'(release_en[9]), 32'd1);
      do_reset();

      // Two tokens of ID 5 with overlapping expiry.
      req_valid = 1'b1; req_id = 4'd5; req_delay = 8'd4;
      tick();
      req_valid = 1'b1; req_id = 4'd5; req_delay = 8'd1;
      tick();
      @(negedge clk);
      chk("t4_rel5_c2", 32'(release_en[5]), 32'd0);
      tick();
      @(negedge clk);
      chk("t4_rel5_c3", 32'(release_en[5]), 32'd1);
      tick();
      tick();
      done_valid = 1'b1; done_id = 4'd5;
      tick();
      @(negedge clk);
      chk("t4_rel5_one_left", 32'(release_en[5]), 32'd1);
      done_valid = 1'b1; done_id = 4'd5;
      tick();
      @(negedge clk);
      chk("t4_rel5_cleared", 32'(release_en[5]), 32'd0);
      chk("t4_occ", 32'(occupancy), 32'd0);

      // Done with nothing to retire.
      done_valid = 1'b1; done_id = 4'd9;
      tick();
      @(negedge clk);
      chk("t5_err_set", 32'(err), 32'd1);
      chk("t5_occ", 32'(occupancy), 32'd0);
      tick();
      tick();
      @(negedge clk);
      chk("t5_err_sticky", 32'(err), 32'd1);

      // Simultaneous accept and retire, then reset mid-countdown.
      req_valid = 1'b1; req_id = 4'd4; req_delay = 8'd0;
      tick();
      @(negedge clk);
      chk("t6_rel4", 32'(release_en[4]), 32'd1);
      req_valid = 1'b1; req_id = 4'd1; req_delay = 8'd20;
      done_valid = 1'b1; done_id = 4'd4;
      tick();
      @(negedge clk);
      chk("t6_occ_pair", 32'(occupancy), 32'd1);
      chk("t6_rel4_low", 32'(release_en[4]), 32'd0);
      req_valid = 1'b1; req_id = 4'd7; req_delay = 8'd30;
      tick();
      tick();
      rst = 1'b1;
      @(negedge clk);
      chk("t6_ready_in_reset", 32'(req_ready), 32'd0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("t6_rel_after_reset", 32'(release_en), 32'd0);
      chk("t6_occ_after_reset", 32'(occupancy), 32'd0);
      chk("t6_err_after_reset", 32'(err), 32'd0);
      chk("t6_ready_after_reset", 32'(req_ready), 32'd1);

      // Randomized traffic, checked by the model every cycle.
      for (int n = 0; n < 4000; n++) begin
         req_valid = ($urandom_range(0, 99) < 60);
         req_id    = 4'($urandom_range(0, 15));
         req_delay = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 40))
                                                 : 8'($urandom_range(0, 6));
         done_valid = 1'b0;
         cands.delete();
         foreach (m_id[i])
            if (m_rel[i] <= cyc) cands.push_back(m_id[i]);
         if ($urandom_range(0, 99) < 50 && cands.size() > 0) begin
            done_valid = 1'b1;
            done_id    = 4'(cands[$urandom_range(0, cands.size() - 1)]);
         end else if ($urandom_range(0, 99) < 2) begin
            done_valid = 1'b1;
            done_id    = 4'($urandom_range(0, 15));
         end
         rst = ($urandom_range(0, 299) == 0);
         tick_hold();
      end
      rst = 1'b0; req_valid = 1'b0; done_valid = 1'b0;
      tick();
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
